// File: rtl/risc_pkg.sv
// -----------------------------------------------------------------------------
// risc_pkg
// Shared definitions for the 16-bit multi-cycle RISC core: opcode values,
// datapath select encodings (also used by Execute), the main controller state
// enum and the control-word struct that the controller drives.
// -----------------------------------------------------------------------------
package risc_pkg;

  // Opcodes held in IR[15:12]
  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_LW    = 4'h1;
  localparam logic [3:0] OP_SW    = 4'h2;
  localparam logic [3:0] OP_BEQ   = 4'h3;
  localparam logic [3:0] OP_ADDI  = 4'h4;
  localparam logic [3:0] OP_J     = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // ALU operation requested from Execute
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  // ALU B-operand select
  typedef enum logic [1:0] {
    SRCB_REG = 2'b00,
    SRCB_ONE = 2'b01,
    SRCB_IMM = 2'b10
  } alu_src_b_t;

  // Next-PC select
  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_t;

  // Main controller states
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_R_WB,
    S_EXEC_I,
    S_I_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_LW_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_HALT
  } state_t;

  // One cycle's worth of datapath control
  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    pc_src_t    pc_source;
    logic       halted;
  } ctrl_t;

  // True for every opcode the core implements (HALT included)
  function automatic logic is_defined_op(input logic [3:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_HALT: is_defined_op = 1'b1;
      default:                                               is_defined_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Moore main controller for the multi-cycle 16-bit RISC core. Steps the shared
// datapath through fetch / decode / execute / memory / write-back and counts
// retired instructions (saturating).
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   opcode              IR[15:12], valid once IR is latched
//   zero                Zero flag from Execute (BEQ decision)
//   mem_ready           unified memory finishes the current access this cycle
//   pc_write, ir_write  PC / IR load enables
//   i_or_d              memory address: 0 = PC, 1 = ALUOut
//   mem_read, mem_write memory requests
//   reg_write           register-file write enable
//   mem_to_reg          write-back source: 0 = ALU, 1 = MDR
//   RegDst              destination register: 1 = rd, 0 = rt
//   alu_src_a           ALU A: 0 = PC, 1 = read_data_1
//   ALUSrc              ALU B select (alu_src_b_t)
//   ALUOp               ALU operation (alu_op_t)
//   pc_source           next-PC select (pc_src_t)
//   halted              core stopped in HALT
//   illegal             sticky: an undefined opcode was decoded
//   retired             completed instructions, saturating at 2^CNT_W-1
// -----------------------------------------------------------------------------
module multicycle_control
  import risc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             RegDst,
  output logic             alu_src_a,
  output logic [1:0]       ALUSrc,
  output logic [1:0]       ALUOp,
  output logic [1:0]       pc_source,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [CNT_W-1:0] RETIRED_MAX = '1;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_retire;
  logic [CNT_W-1:0] r_retired;
  logic             r_illegal;
  ctrl_t            w_ctrl;

  // ---------------------------------------------------------------------------
  // Next-state decode. w_retire marks the edges that leave the last state of
  // an instruction, so the counter moves exactly when the instruction commits.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    w_next_state = r_state;
    w_retire     = 1'b0;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next_state = S_EXEC_R;
          OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_EXEC_I;
          OP_J:         w_next_state = S_JUMP;
          default:      w_next_state = S_HALT;  // HALT and undefined opcodes
        endcase
      end
      S_EXEC_R:   w_next_state = S_R_WB;
      S_EXEC_I:   w_next_state = S_I_WB;
      S_MEM_ADDR: w_next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) w_next_state = S_LW_WB;
      S_MEM_WR: begin
        if (mem_ready) begin
          w_next_state = S_FETCH;
          w_retire     = 1'b1;
        end
      end
      S_R_WB, S_I_WB, S_LW_WB, S_BRANCH, S_JUMP: begin
        w_next_state = S_FETCH;
        w_retire     = 1'b1;
      end
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, retired counter and sticky illegal flag.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every register updating from the
    // values sampled at the same edge, independent of statement order.
    if (rst) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_retire && (r_retired != RETIRED_MAX)) r_retired <= r_retired + 1'b1;
      if ((r_state == S_DECODE) && !is_defined_op(opcode)) r_illegal <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode: Moore from the state, except the fetch enables (gated by
  // mem_ready so PC/IR load once per fetch) and the branch PC load (gated by
  // zero). Everything is forced low while rst is held, even though the state
  // register already reads FETCH.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRCB_ONE;
        w_ctrl.ir_write  = mem_ready;
        w_ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        w_ctrl.alu_src_b = SRCB_IMM;   // branch target precompute
      end
      S_EXEC_R: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
      end
      S_I_WB: begin
        w_ctrl.reg_write = 1'b1;
      end
      S_MEM_RD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = 1'b1;
      end
      S_LW_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_op    = ALUOP_SUB;
        w_ctrl.pc_source = PCSRC_ALUOUT;
        w_ctrl.pc_write  = zero;
      end
      S_JUMP: begin
        w_ctrl.pc_source = PCSRC_JUMP;
        w_ctrl.pc_write  = 1'b1;
      end
      S_HALT: begin
        w_ctrl.halted = 1'b1;
      end
      default: w_ctrl = '0;
    endcase
    if (rst) w_ctrl = '0;
  end

  assign pc_write   = w_ctrl.pc_write;
  assign i_or_d     = w_ctrl.i_or_d;
  assign mem_read   = w_ctrl.mem_read;
  assign mem_write  = w_ctrl.mem_write;
  assign ir_write   = w_ctrl.ir_write;
  assign reg_write  = w_ctrl.reg_write;
  assign mem_to_reg = w_ctrl.mem_to_reg;
  assign RegDst     = w_ctrl.reg_dst;
  assign alu_src_a  = w_ctrl.alu_src_a;
  assign ALUSrc     = w_ctrl.alu_src_b;
  assign ALUOp      = w_ctrl.alu_op;
  assign pc_source  = w_ctrl.pc_source;
  assign halted     = w_ctrl.halted;
  assign illegal    = r_illegal;
  assign retired    = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Drives whole instructions into two controller instances (CNT_W=16 and
// CNT_W=2) with random memory wait states. Expected per-cycle enables come
// from an instruction timeline: a fetch access, one decode cycle, then the
// opcode's own steps, each memory access stretched by its wait count.
// -----------------------------------------------------------------------------
module tb_multicycle_control;
  import risc_pkg::*;

  // Enable vector layout: {mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write, halted}
  localparam logic [6:0] EN_MRD = 7'b1000000;
  localparam logic [6:0] EN_MWR = 7'b0100000;
  localparam logic [6:0] EN_IOD = 7'b0010000;
  localparam logic [6:0] EN_IRW = 7'b0001000;
  localparam logic [6:0] EN_PCW = 7'b0000100;
  localparam logic [6:0] EN_RGW = 7'b0000010;
  localparam logic [6:0] EN_HLT = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  opcode;
  logic        zero;
  logic        mem_ready;

  logic        pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic        mem_to_reg, RegDst, alu_src_a, halted, illegal;
  logic [1:0]  ALUSrc, ALUOp, pc_source;
  logic [15:0] retired;

  logic        d2_pc_write, d2_i_or_d, d2_mem_read, d2_mem_write, d2_ir_write;
  logic        d2_reg_write, d2_mem_to_reg, d2_RegDst, d2_alu_src_a, d2_halted;
  logic        d2_illegal;
  logic [1:0]  d2_ALUSrc, d2_ALUOp, d2_pc_source;
  logic [1:0]  d2_retired;

  int checks = 0;
  int errors = 0;

  // Reference state
  int unsigned m_ret16;
  int unsigned m_ret2;
  logic        m_ill;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .RegDst(RegDst),
    .alu_src_a(alu_src_a), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .pc_source(pc_source),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  multicycle_control #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(d2_pc_write), .i_or_d(d2_i_or_d), .mem_read(d2_mem_read),
    .mem_write(d2_mem_write), .ir_write(d2_ir_write), .reg_write(d2_reg_write),
    .mem_to_reg(d2_mem_to_reg), .RegDst(d2_RegDst), .alu_src_a(d2_alu_src_a),
    .ALUSrc(d2_ALUSrc), .ALUOp(d2_ALUOp), .pc_source(d2_pc_source),
    .halted(d2_halted), .illegal(d2_illegal), .retired(d2_retired)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [6:0] enables();
    return {mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write, halted};
  endfunction

  task automatic check_counters(input string tag);
    check({tag, " retired16"}, 32'(retired), m_ret16);
    check({tag, " retired2"}, 32'(d2_retired), m_ret2);
    check({tag, " illegal"}, 32'(illegal), 32'(m_ill));
  endtask

  // Called one step after a rising edge; leaves rst low one step after an edge.
  task automatic do_reset();
    rst       = 1'b1;
    mem_ready = 1'b1;
    opcode    = OP_RTYPE;
    zero      = 1'b1;
    #1;
    m_ret16 = 0;
    m_ret2  = 0;
    m_ill   = 1'b0;
    check("reset async enables", 32'(enables()), 32'(7'd0));
    check_counters("reset async");
    @(negedge clk);
    check("reset held enables", 32'(enables()), 32'(7'd0));
    check("reset held d2 mem_read", 32'(d2_mem_read), 32'(1'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Runs one instruction from its first fetch cycle. fw/dw are the wait
  // cycles of the fetch access and of the data access.
  task automatic run_instr(input logic [3:0] op, input int fw, input int dw, input logic z);
    logic [6:0] en  [16];
    logic       rdy [16];
    int         len;
    int         p;
    bit         stops;
    string      t;

    stops = 1'b0;
    for (int i = 0; i < 16; i++) begin
      en[i]  = '0;
      rdy[i] = 1'($urandom);    // mem_ready is ignored outside memory accesses
    end
    for (int c = 0; c <= fw; c++) begin
      en[c]  = EN_MRD;
      rdy[c] = (c == fw);
    end
    en[fw] = EN_MRD | EN_IRW | EN_PCW;
    p = fw + 2;                 // first cycle after decode
    case (op)
      OP_RTYPE, OP_ADDI: begin
        en[p + 1] = EN_RGW;
        len = fw + 4;
      end
      OP_LW: begin
        for (int c = p + 1; c <= p + 1 + dw; c++) begin
          en[c]  = EN_MRD | EN_IOD;
          rdy[c] = (c == p + 1 + dw);
        end
        en[p + 2 + dw] = EN_RGW;
        len = fw + 5 + dw;
      end
      OP_SW: begin
        for (int c = p + 1; c <= p + 1 + dw; c++) begin
          en[c]  = EN_MWR | EN_IOD;
          rdy[c] = (c == p + 1 + dw);
        end
        len = fw + 4 + dw;
      end
      OP_BEQ: begin
        en[p] = z ? EN_PCW : 7'd0;
        len = fw + 3;
      end
      OP_J: begin
        en[p] = EN_PCW;
        len = fw + 3;
      end
      default: begin
        stops = 1'b1;
        len = fw + 2;
      end
    endcase

    for (int c = 0; c < len; c++) begin
      opcode    = op;
      zero      = z;
      mem_ready = rdy[c];
      @(negedge clk);
      t = $sformatf("op%0h fw%0d dw%0d c%0d", op, fw, dw, c);
      check({t, " enables"}, 32'(enables()), 32'(en[c]));
      check({t, " rd/wr exclusive"}, 32'(mem_read & mem_write), 32'(1'b0));
      check({t, " rw/pcw exclusive"}, 32'(reg_write & pc_write), 32'(1'b0));
      if (c == fw) begin
        check({t, " fetch ALUSrc"}, 32'(ALUSrc), 32'(SRCB_ONE));
        check({t, " fetch pc_source"}, 32'(pc_source), 32'(PCSRC_ALU));
      end
      if (c == fw + 1) begin
        check({t, " decode ALUSrc"}, 32'(ALUSrc), 32'(SRCB_IMM));
        check({t, " decode alu_src_a"}, 32'(alu_src_a), 32'(1'b0));
      end
      if (op == OP_RTYPE && c == p) begin
        check({t, " exec ALUOp"}, 32'(ALUOp), 32'(ALUOP_FUNCT));
        check({t, " exec alu_src_a"}, 32'(alu_src_a), 32'(1'b1));
      end
      if (op == OP_RTYPE && c == p + 1) check({t, " wb RegDst"}, 32'(RegDst), 32'(1'b1));
      if (op == OP_ADDI && c == p + 1) check({t, " wb RegDst"}, 32'(RegDst), 32'(1'b0));
      if (op == OP_LW && c == len - 1) check({t, " wb mem_to_reg"}, 32'(mem_to_reg), 32'(1'b1));
      if (op == OP_BEQ && c == p) begin
        check({t, " beq pc_source"}, 32'(pc_source), 32'(PCSRC_ALUOUT));
        check({t, " beq ALUOp"}, 32'(ALUOp), 32'(ALUOP_SUB));
      end
      if (op == OP_J && c == p) check({t, " j pc_source"}, 32'(pc_source), 32'(PCSRC_JUMP));
      @(posedge clk);
      #1;
    end

    if (!stops) begin
      if (m_ret16 < 32'd65535) m_ret16++;
      if (m_ret2 < 32'd3) m_ret2++;
    end else if (!is_defined_op(op)) begin
      m_ill = 1'b1;
    end
    check_counters($sformatf("after op%0h", op));

    if (stops) begin
      for (int c = 0; c < 4; c++) begin
        mem_ready = 1'($urandom);
        opcode    = 4'($urandom);
        @(negedge clk);
        check($sformatf("halted c%0d enables", c), 32'(enables()), 32'(EN_HLT));
        @(posedge clk);
        #1;
      end
      check_counters("halt hold");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rop;
    rst       = 1'b1;
    opcode    = OP_RTYPE;
    zero      = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Directed: one of each, including the LW with two data wait cycles
    run_instr(OP_RTYPE, 0, 0, 1'b0);
    run_instr(OP_LW,    0, 2, 1'b0);
    run_instr(OP_BEQ,   0, 0, 1'b1);
    run_instr(OP_BEQ,   0, 0, 1'b0);
    run_instr(OP_ADDI,  0, 0, 1'b1);
    run_instr(OP_SW,    1, 1, 1'b0);
    run_instr(OP_J,     2, 0, 1'b1);

    // Random instruction stream with random wait states
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(5, 0));
      run_instr(rop, int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), 1'($urandom));
    end

    // Undefined opcode 7, then reset clears halted/illegal
    run_instr(4'h7, 0, 0, 1'b0);
    do_reset();
    run_instr(OP_RTYPE, 0, 0, 1'b0);
    run_instr(OP_HALT, 1, 0, 1'b0);
    do_reset();
    run_instr(4'($urandom_range(14, 6)), 0, 0, 1'b1);
    do_reset();

    // Reset in the middle of a store with the memory stalling
    run_instr(OP_ADDI, 0, 0, 1'b0);
    opcode    = OP_SW;
    zero      = 1'b0;
    mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    check("sw stall mem_write", 32'(mem_write), 32'(1'b1));
    #1;
    rst = 1'b1;
    #1;
    m_ret16 = 0;
    m_ret2  = 0;
    check("sw reset enables", 32'(enables()), 32'(7'd0));
    check_counters("sw reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_instr(OP_RTYPE, 0, 0, 1'b0);

    // Saturation of the 2-bit counter
    do_reset();
    for (int i = 0; i < 5; i++) run_instr(OP_J, 0, 0, 1'b0);
    check("sat retired2", 32'(d2_retired), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
